llr_frame_buf_ctrl: RTL and testbench

Ingress scheduler between the channel LLR stream and the decoder's ram_llr. It accepts frames into an N-slot circular frame buffer RAM and reports the committed frame count to the decoder controller as flag_buffer_in. On each flag_org_update pulse it copies the oldest frame into ram_llr, then pulses flag_org_write_end. The buffer RAM is external, simple dual-port, with 1-cycle read latency.

---
 rtl/ldpc_buf_pkg.sv | 23 ++
 rtl/llr_frame_rd_seq.sv | 100 ++++++++++
 rtl/llr_frame_buf_ctrl.sv | 119 +++++++++++
 tb/tb_llr_frame_buf_ctrl.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ldpc_buf_pkg.sv
// Shared definitions for the LLR ingress frame buffer and the decoder ram_llr.
//   FRAME_WORDS_DEF / DATA_W_DEF : default frame geometry, shared with ram_llr
//   rd_state_t                   : states of the frame-copy (read) sequencer
//   slot_next()                  : circular advance of a 2-bit slot pointer
package ldpc_buf_pkg;

    localparam int FRAME_WORDS_DEF = 512;
    localparam int DATA_W_DEF      = 64;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_XFER = 2'd1,
        R_LAST = 2'd2,
        R_DONE = 2'd3
    } rd_state_t;

    // Advance a slot pointer, wrapping from n_slots-1 back to 0.
    function automatic logic [1:0] slot_next(input logic [1:0] slot,
                                             input int unsigned n_slots);
        return (slot == 2'(n_slots - 1)) ? 2'd0 : slot + 2'd1;
    endfunction

endpackage

// File: rtl/llr_frame_rd_seq.sv
// Frame-copy sequencer: on a load request, streams the oldest committed frame
// out of the buffer RAM and writes it into ram_llr, then pulses write_end.
// Ports:
//   sys_clk, sys_rst     : clock, asynchronous active-high reset
//   flag_org_update      : single-cycle load request (ignored unless idle)
//   frames_avail         : at least one committed frame is waiting
//   buf_re/buf_raddr     : buffer RAM read port
//   buf_rdata            : buffer RAM read data, valid 1 cycle after buf_re
//   llr_we/llr_waddr/llr_wdata : ram_llr write port
//   flag_org_write_end   : one-cycle pulse, frame fully written into ram_llr
//   rd_state             : current sequencer state (debug / frame-free strobe)
//
// Handshake: there is no backpressure on either RAM. A read issued in cycle
// C returns data in C+1, which is exactly when the registered llr_we/llr_waddr
// copy of that read appears, so buf_rdata is forwarded to llr_wdata as-is.
module llr_frame_rd_seq
    import ldpc_buf_pkg::*;
#(
    parameter int N_SLOTS     = 2,
    parameter int FRAME_WORDS = FRAME_WORDS_DEF,
    parameter int DATA_W      = DATA_W_DEF,
    parameter int AW          = $clog2(N_SLOTS * FRAME_WORDS),
    parameter int LW          = $clog2(FRAME_WORDS)
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              flag_org_update,
    input  logic              frames_avail,
    output logic              buf_re,
    output logic [AW-1:0]     buf_raddr,
    input  logic [DATA_W-1:0] buf_rdata,
    output logic              llr_we,
    output logic [LW-1:0]     llr_waddr,
    output logic [DATA_W-1:0] llr_wdata,
    output logic              flag_org_write_end,
    output rd_state_t         rd_state
);

    localparam logic [LW-1:0] LAST_IDX = LW'(FRAME_WORDS - 1);

    logic [1:0]    rd_slot;
    logic [LW-1:0] rd_cnt;

    // rd_cnt always holds the index of the read being issued this cycle.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            rd_state           <= R_IDLE;
            rd_slot            <= 2'd0;
            rd_cnt             <= '0;
            buf_re             <= 1'b0;
            buf_raddr          <= '0;
            flag_org_write_end <= 1'b0;
        end else begin
            case (rd_state)
                R_IDLE: begin
                    if (flag_org_update && frames_avail) begin
                        rd_state  <= R_XFER;
                        rd_cnt    <= '0;
                        buf_re    <= 1'b1;
                        buf_raddr <= AW'(rd_slot) * AW'(FRAME_WORDS);
                    end
                end
                R_XFER: begin
                    if (rd_cnt == LAST_IDX) begin
                        rd_state <= R_LAST;
                        buf_re   <= 1'b0;
                    end else begin
                        rd_cnt    <= rd_cnt + LW'(1);
                        buf_raddr <= buf_raddr + AW'(1);
                    end
                end
                R_LAST: begin
                    // Final read data is landing in ram_llr this cycle.
                    rd_state           <= R_DONE;
                    flag_org_write_end <= 1'b1;
                end
                R_DONE: begin
                    rd_state           <= R_IDLE;
                    flag_org_write_end <= 1'b0;
                    rd_slot            <= slot_next(rd_slot, N_SLOTS);
                end
                default: rd_state <= R_IDLE;
            endcase
        end
    end

    // ram_llr write path: one cycle behind the read issue.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            llr_we    <= 1'b0;
            llr_waddr <= '0;
        end else begin
            llr_we    <= buf_re;
            llr_waddr <= rd_cnt;
        end
    end

    assign llr_wdata = buf_rdata;

endmodule

// File: rtl/llr_frame_buf_ctrl.sv
// Ingress scheduler: writes channel LLR frames into an N-slot circular buffer
// RAM, tracks how many complete frames are waiting, and copies the oldest
// frame into ram_llr on each flag_org_update request.
// Ports:
//   sys_clk, sys_rst            : clock, asynchronous active-high reset
//   in_valid/in_ready/in_data/in_last : LLR word stream (word moves when
//                                 in_valid && in_ready in the same cycle)
//   buf_we/buf_waddr/buf_wdata  : buffer RAM write port
//   buf_re/buf_raddr/buf_rdata  : buffer RAM read port (1-cycle latency)
//   flag_org_update             : load-next-frame request from the controller
//   llr_we/llr_waddr/llr_wdata  : ram_llr write port
//   flag_buffer_in              : committed frames waiting
//   flag_org_write_end          : one-cycle pulse after a frame reaches ram_llr
//   err_len                     : one-cycle pulse, cycle after a length error
module llr_frame_buf_ctrl
    import ldpc_buf_pkg::*;
#(
    parameter int N_SLOTS     = 2,
    parameter int FRAME_WORDS = FRAME_WORDS_DEF,
    parameter int DATA_W      = DATA_W_DEF,
    parameter int AW          = $clog2(N_SLOTS * FRAME_WORDS),
    parameter int LW          = $clog2(FRAME_WORDS)
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              buf_we,
    output logic [AW-1:0]     buf_waddr,
    output logic [DATA_W-1:0] buf_wdata,
    output logic              buf_re,
    output logic [AW-1:0]     buf_raddr,
    input  logic [DATA_W-1:0] buf_rdata,
    input  logic              flag_org_update,
    output logic              llr_we,
    output logic [LW-1:0]     llr_waddr,
    output logic [DATA_W-1:0] llr_wdata,
    output logic [1:0]        flag_buffer_in,
    output logic              flag_org_write_end,
    output logic              err_len
);

    logic [1:0]    count;
    logic [1:0]    wr_slot;
    logic [LW-1:0] wr_cnt;
    rd_state_t     rd_state;
    logic          accept;
    logic          commit;
    logic          early_last;
    logic          frame_free;

    // Write slot can never be a committed slot: with count < N_SLOTS the
    // write pointer always sits on a free slot, so reads and writes never
    // collide.
    assign in_ready   = (count < 2'(N_SLOTS));
    assign accept     = in_valid && in_ready;
    assign commit     = accept && (wr_cnt == LW'(FRAME_WORDS - 1));
    assign early_last = accept && in_last && !commit;
    assign frame_free = (rd_state == R_DONE);

    assign buf_we    = accept;
    assign buf_waddr = AW'(wr_slot) * AW'(FRAME_WORDS) + AW'(wr_cnt);
    assign buf_wdata = in_data;

    assign flag_buffer_in = count;

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            count   <= 2'd0;
            wr_slot <= 2'd0;
            wr_cnt  <= '0;
            err_len <= 1'b0;
        end else begin
            // A full-length frame is committed even without in_last; a short
            // frame is dropped by rewinding wr_cnt within the same slot.
            err_len <= (commit && !in_last) || early_last;

            if (commit) begin
                wr_cnt  <= '0;
                wr_slot <= slot_next(wr_slot, N_SLOTS);
            end else if (early_last) begin
                wr_cnt <= '0;
            end else if (accept) begin
                wr_cnt <= wr_cnt + LW'(1);
            end

            // Commit and free in the same cycle cancel out.
            case ({commit, frame_free})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    llr_frame_rd_seq #(
        .N_SLOTS     (N_SLOTS),
        .FRAME_WORDS (FRAME_WORDS),
        .DATA_W      (DATA_W),
        .AW          (AW),
        .LW          (LW)
    ) u_rd_seq (
        .sys_clk            (sys_clk),
        .sys_rst            (sys_rst),
        .flag_org_update    (flag_org_update),
        .frames_avail       (count != 2'd0),
        .buf_re             (buf_re),
        .buf_raddr          (buf_raddr),
        .buf_rdata          (buf_rdata),
        .llr_we             (llr_we),
        .llr_waddr          (llr_waddr),
        .llr_wdata          (llr_wdata),
        .flag_org_write_end (flag_org_write_end),
        .rd_state           (rd_state)
    );

endmodule

// File: tb/tb_llr_frame_buf_ctrl.sv
module tb_llr_frame_buf_ctrl;

  localparam int N  = 2;
  localparam int FW = 8;
  localparam int DW = 16;
  localparam int AW = 4;
  localparam int LW = 3;

  // ---------------- clock / reset ----------------
  logic sys_clk = 1'b0;
  logic sys_rst = 1'b0;
  always #5 sys_clk = ~sys_clk;

  logic          in_valid, in_ready, in_last;
  logic [DW-1:0] in_data;
  logic          buf_we, buf_re;
  logic [AW-1:0] buf_waddr, buf_raddr;
  logic [DW-1:0] buf_wdata, buf_rdata;
  logic          flag_org_update, llr_we, flag_org_write_end, err_len;
  logic [LW-1:0] llr_waddr;
  logic [DW-1:0] llr_wdata;
  logic [1:0]    flag_buffer_in;

  llr_frame_buf_ctrl #(
    .N_SLOTS(N), .FRAME_WORDS(FW), .DATA_W(DW)
  ) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .buf_we(buf_we), .buf_waddr(buf_waddr), .buf_wdata(buf_wdata),
    .buf_re(buf_re), .buf_raddr(buf_raddr), .buf_rdata(buf_rdata),
    .flag_org_update(flag_org_update),
    .llr_we(llr_we), .llr_waddr(llr_waddr), .llr_wdata(llr_wdata),
    .flag_buffer_in(flag_buffer_in), .flag_org_write_end(flag_org_write_end),
    .err_len(err_len)
  );

  // External buffer RAM: simple dual-port, 1-cycle read latency.
  logic [DW-1:0] mem [0:N*FW-1];
  always @(posedge sys_clk) begin
    if (buf_we) mem[buf_waddr] <= buf_wdata;
    if (buf_re) buf_rdata <= mem[buf_raddr];
  end

  // ---------------- reference model ----------------
  // exp_q holds the words of every committed, not-yet-copied frame, oldest first.
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] part_q[$];
  int wr_slot_m, rd_slot_m, busy_m, t_start, cyc;
  logic err_exp;
  int n_err = 0;
  int n_chk = 0;

  function automatic int frames_waiting();
    return exp_q.size() / FW;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    part_q.delete();
    wr_slot_m = 0;
    rd_slot_m = 0;
    busy_m    = 0;
    err_exp   = 1'b0;
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic v, input logic [DW-1:0] d, input logic l, input logic u);
    in_valid        = v;
    in_data         = d;
    in_last         = l;
    flag_org_update = u;
  endtask

  // One clock cycle: check this cycle's outputs, advance the model across the
  // edge, then check registered outputs after it.
  task automatic step();
    int k;
    int cnt_pre;
    bit acc, re_e, we_e, end_e;
    #1;
    cnt_pre = frames_waiting();
    acc = in_valid && (cnt_pre < N);
    chk("in_ready", in_ready, cnt_pre < N);
    chk("buf_we", buf_we, acc);
    if (acc) begin
      chk("buf_waddr", buf_waddr, wr_slot_m * FW + part_q.size());
      chk("buf_wdata", buf_wdata, in_data);
    end
    k = busy_m ? (cyc - t_start) : 0;
    re_e  = busy_m && k >= 1 && k <= FW;
    we_e  = busy_m && k >= 2 && k <= FW + 1;
    end_e = busy_m && k == FW + 2;
    chk("buf_re", buf_re, re_e);
    if (re_e) chk("buf_raddr", buf_raddr, rd_slot_m * FW + k - 1);
    chk("llr_we", llr_we, we_e);
    if (we_e) begin
      chk("llr_waddr", llr_waddr, k - 2);
      chk("llr_wdata", llr_wdata, exp_q[k-2]);
    end
    chk("write_end", flag_org_write_end, end_e);

    // model update for this edge
    err_exp = 1'b0;
    if (acc) begin
      if (part_q.size() == FW - 1) begin
        foreach (part_q[i]) exp_q.push_back(part_q[i]);
        exp_q.push_back(in_data);
        part_q.delete();
        err_exp   = !in_last;
        wr_slot_m = (wr_slot_m + 1) % N;
      end else if (in_last) begin
        part_q.delete();
        err_exp = 1'b1;
      end else begin
        part_q.push_back(in_data);
      end
    end
    if (end_e) begin
      for (int i = 0; i < FW; i++) void'(exp_q.pop_front());
      rd_slot_m = (rd_slot_m + 1) % N;
      busy_m    = 0;
    end else if (!busy_m && flag_org_update && cnt_pre != 0) begin
      busy_m  = 1;
      t_start = cyc;
    end

    @(posedge sys_clk);
    cyc++;
    @(negedge sys_clk);
    chk("err_len", err_len, err_exp);
    chk("flag_buffer_in", flag_buffer_in, frames_waiting());
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      drive(1'b0, '0, 1'b0, 1'b0);
      step();
    end
  endtask

  task automatic send_frame(input int len, input int last_pos);
    for (int i = 0; i < len; i++) begin
      drive(1'b1, DW'($urandom_range(0, 65535)), (i == last_pos), 1'b0);
      step();
    end
    drive(1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic request();
    drive(1'b0, '0, 1'b0, 1'b1);
    step();
  endtask

  task automatic do_reset();
    sys_rst = 1'b1;
    drive(1'b0, '0, 1'b0, 1'b0);
    #1;
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_buffer_in", flag_buffer_in, 2'd0);
    chk("rst_err_len", err_len, 1'b0);
    chk("rst_buf_re", buf_re, 1'b0);
    chk("rst_llr_we", llr_we, 1'b0);
    chk("rst_write_end", flag_org_write_end, 1'b0);
    chk("rst_buf_we", buf_we, 1'b0);
    model_reset();
    @(posedge sys_clk);
    cyc++;
    @(negedge sys_clk);
    sys_rst = 1'b0;
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    cyc = 0;
    drive(1'b0, '0, 1'b0, 1'b0);
    #2;
    do_reset();

    // single frame into slot 0, then copy it out
    send_frame(FW, FW - 1);
    idle(1);
    request();
    idle(11);

    // three back-to-back frames: the third stalls
    send_frame(FW, FW - 1);
    send_frame(FW, FW - 1);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, DW'($urandom_range(0, 65535)), 1'b0, 1'b0);
      step();
    end
    idle(1);

    // drain one frame with an extra request mid-transfer (ignored)
    request();
    idle(2);
    request();
    idle(7);

    // copy the next frame while a new frame's final word lands on the free cycle
    request();
    idle(2);
    send_frame(FW, FW - 1);
    idle(1);

    // drain the remaining frame
    request();
    idle(11);

    // short frame (discarded), full frame, then a full frame without in_last
    send_frame(5, 4);
    idle(1);
    send_frame(FW, FW - 1);
    send_frame(FW, -1);
    idle(1);
    request();
    idle(11);
    request();
    idle(11);

    // request with nothing buffered
    request();
    idle(12);

    // reset in the middle of a transfer and a partial frame
    send_frame(FW, FW - 1);
    request();
    idle(4);
    send_frame(3, -1);
    do_reset();
    idle(12);

    // randomized traffic
    for (int i = 0; i < 300; i++) begin
      logic v, l, u;
      v = ($urandom_range(0, 3) != 0);
      l = (part_q.size() == FW - 1) ? ($urandom_range(0, 7) != 0)
                                    : ($urandom_range(0, 15) == 0);
      u = ($urandom_range(0, 5) == 0);
      drive(v, DW'($urandom_range(0, 65535)), l, u);
      step();
    end
    idle(14);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
